// File: rtl/usb_ep0_in_tx.sv
// -----------------------------------------------------------------------------
// usb_ep0_in_tx
//   EP0 IN-direction data responder. Takes the descriptor window chosen by the
//   SETUP decoder, streams the descriptor ROM into the ULPI TX FIFO one
//   MAXPKT-sized packet at a time, answers IN tokens with DATA0/DATA1 and the
//   packet length, and retransmits on handshake timeout. A zero-byte window
//   produces the DATA1 zero-length status packet.
//
// Optional feature (compile-time macro):
//   USB_EP0_TX_ZLP_EN - when defined, a window whose length is a non-zero
//   multiple of MAXPKT is terminated by one extra zero-length packet.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_load          pulse: romaddr/romnum valid, start a new transfer
//   romaddr, romnum   descriptor start address and byte count (0 = status ZLP)
//   setupdataactive   new SETUP in progress; aborts everything
//   rom_addr/rom_data descriptor ROM port (data 1 cycle after address)
//   push_tx/datai_tx  TX FIFO write strobe and data; full_tx back-pressure
//   flush_tx          pulse: discard TX FIFO contents
//   in_token          pulse: IN token addressed to EP0
//   ack_rcvd          pulse: host ACK for the last DATA packet
//   ack_timeout       pulse: no handshake within turnaround window
//   tx_go/tx_pid/tx_len  packet launch pulse, PID and byte count
//   nak               pulse: answer the current IN with NAK
//   busy              transfer in progress
// -----------------------------------------------------------------------------
module usb_ep0_in_tx #(
    parameter int MAXPKT = 64,
    parameter int ROM_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_load,
    input  logic [ROM_AW-1:0] romaddr,
    input  logic [7:0]        romnum,
    input  logic              setupdataactive,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              push_tx,
    output logic [7:0]        datai_tx,
    input  logic              full_tx,
    output logic              flush_tx,
    input  logic              in_token,
    input  logic              ack_rcvd,
    input  logic              ack_timeout,
    output logic              tx_go,
    output logic [3:0]        tx_pid,
    output logic [6:0]        tx_len,
    output logic              nak,
    output logic              busy
);

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [7:0] MAXPKT_B  = 8'(MAXPKT);

    typedef enum logic [2:0] {
        IDLE,
        FILL_ADDR,
        FILL_PUSH,
        WAIT_IN,
        WAIT_HS,
        DONE
    } state_t;

    state_t            state;
    logic [ROM_AW-1:0] base;
    logic [7:0]        remaining;
    logic [7:0]        offset;
    logic [6:0]        cnt;
    logic              toggle;
    logic              zlp_pending;
    logic              sda_q;
    logic [7:0]        pkt_len;
    logic              zlp_on_load;

    // Size of the packet currently being built / sent.
    assign pkt_len = (remaining > MAXPKT_B) ? MAXPKT_B : remaining;

`ifdef USB_EP0_TX_ZLP_EN
    assign zlp_on_load = (romnum != 8'd0) && ((romnum % MAXPKT_B) == 8'd0);
`else
    assign zlp_on_load = 1'b0;
`endif

    // The FIFO write must react to full_tx in the same cycle, so the strobe
    // and data are decoded straight from the FILL_PUSH state.
    assign push_tx  = (state == FILL_PUSH) && !full_tx;
    assign datai_tx = (state == FILL_PUSH) ? rom_data : 8'd0;
    assign busy     = (state == FILL_ADDR) || (state == FILL_PUSH) ||
                      (state == WAIT_IN)   || (state == WAIT_HS);

    // ROM byte address of byte c of the packet starting at off (wraps).
    function automatic logic [ROM_AW-1:0] rom_at(input logic [ROM_AW-1:0] b,
                                                 input logic [7:0]        off,
                                                 input logic [6:0]        c);
        return b + ROM_AW'(off) + ROM_AW'(c);
    endfunction

    // rom_addr is loaded on every transition into FILL_ADDR so the ROM sees
    // it throughout FILL_ADDR and rom_data is valid during FILL_PUSH.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            remaining   <= '0;
            offset      <= '0;
            cnt         <= '0;
            toggle      <= 1'b1;
            zlp_pending <= 1'b0;
            sda_q       <= 1'b0;
            rom_addr    <= '0;
            flush_tx    <= 1'b0;
            tx_go       <= 1'b0;
            tx_pid      <= '0;
            tx_len      <= '0;
            nak         <= 1'b0;
        end else begin
            flush_tx <= 1'b0;
            tx_go    <= 1'b0;
            nak      <= 1'b0;
            sda_q    <= setupdataactive;

            if (setupdataactive) begin
                // Flush only on the first cycle of the abort.
                state       <= IDLE;
                toggle      <= 1'b1;
                remaining   <= '0;
                zlp_pending <= 1'b0;
                cnt         <= '0;
                flush_tx    <= !sda_q;
            end else if (req_load) begin
                state       <= FILL_ADDR;
                base        <= romaddr;
                remaining   <= romnum;
                offset      <= '0;
                cnt         <= '0;
                toggle      <= 1'b1;
                zlp_pending <= zlp_on_load;
                flush_tx    <= 1'b1;
                rom_addr    <= romaddr;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        nak <= in_token;
                    end
                    FILL_ADDR: begin
                        nak   <= in_token;
                        state <= (pkt_len == 8'd0) ? WAIT_IN : FILL_PUSH;
                    end
                    FILL_PUSH: begin
                        nak <= in_token;
                        if (!full_tx) begin
                            cnt <= cnt + 7'd1;
                            if (8'(cnt + 7'd1) == pkt_len) begin
                                state <= WAIT_IN;
                            end else begin
                                rom_addr <= rom_at(base, offset, cnt + 7'd1);
                                state    <= FILL_ADDR;
                            end
                        end
                    end
                    WAIT_IN: begin
                        if (in_token) begin
                            tx_go  <= 1'b1;
                            tx_pid <= toggle ? PID_DATA1 : PID_DATA0;
                            tx_len <= pkt_len[6:0];
                            state  <= WAIT_HS;
                        end
                    end
                    WAIT_HS: begin
                        if (ack_rcvd) begin
                            offset    <= offset + pkt_len;
                            remaining <= remaining - pkt_len;
                            toggle    <= !toggle;
                            cnt       <= '0;
                            if (remaining != pkt_len) begin
                                rom_addr <= rom_at(base, offset + pkt_len, 7'd0);
                                state    <= FILL_ADDR;
                            end else if (zlp_pending) begin
                                zlp_pending <= 1'b0;
                                state       <= WAIT_IN;
                            end else begin
                                state <= DONE;
                            end
                        end else if (ack_timeout || in_token) begin
                            // A repeated IN means our ACK never arrived:
                            // rebuild the same packet and NAK this token.
                            flush_tx <= 1'b1;
                            cnt      <= '0;
                            rom_addr <= rom_at(base, offset, 7'd0);
                            nak      <= in_token;
                            state    <= FILL_ADDR;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_ep0_in_tx.sv
// -----------------------------------------------------------------------------
// tb_usb_ep0_in_tx
//   Self-checking bench for usb_ep0_in_tx. A host model issues IN tokens and
//   handshakes; a FIFO model collects pushed bytes; expected packets are built
//   from the window (address, length, MAXPKT) with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_usb_ep0_in_tx;

    localparam int MAXPKT = 64;
    localparam int ROM_AW = 9;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

`ifdef USB_EP0_TX_ZLP_EN
    localparam bit ZLP_EN = 1'b1;
`else
    localparam bit ZLP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_load = 1'b0;
    logic [ROM_AW-1:0] romaddr = '0;
    logic [7:0]        romnum = '0;
    logic              setupdataactive = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              push_tx;
    logic [7:0]        datai_tx;
    logic              full_tx = 1'b0;
    logic              flush_tx;
    logic              in_token = 1'b0;
    logic              ack_rcvd = 1'b0;
    logic              ack_timeout = 1'b0;
    logic              tx_go;
    logic [3:0]        tx_pid;
    logic [6:0]        tx_len;
    logic              nak;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int push_while_full = 0;

    logic [7:0] rom [512];
    logic [7:0] fifo [$];

    usb_ep0_in_tx #(.MAXPKT(MAXPKT), .ROM_AW(ROM_AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_load        (req_load),
        .romaddr         (romaddr),
        .romnum          (romnum),
        .setupdataactive (setupdataactive),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .push_tx         (push_tx),
        .datai_tx        (datai_tx),
        .full_tx         (full_tx),
        .flush_tx        (flush_tx),
        .in_token        (in_token),
        .ack_rcvd        (ack_rcvd),
        .ack_timeout     (ack_timeout),
        .tx_go           (tx_go),
        .tx_pid          (tx_pid),
        .tx_len          (tx_len),
        .nak             (nak),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Synchronous descriptor ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // TX FIFO model: flush empties it, push appends.
    always @(negedge clk) begin
        if (flush_tx) fifo.delete();
        if (push_tx) begin
            fifo.push_back(datai_tx);
            if (full_tx) push_while_full++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete control IN data stage against the expected packet list.
    // to_pkt / lost_pkt: packet index that first suffers a timeout / lost ACK.
    // stall_at: cycles after load at which full_tx is held high for 5 cycles.
    task automatic run_transfer(input logic [ROM_AW-1:0] addr, input logic [7:0] num,
                                input int to_pkt, input int lost_pkt, input int stall_at);
        int exp_pid[$];
        int exp_len[$];
        int exp_off[$];
        int rem, off, tog, n, tries, bad_idx;
        bit pkt_done, retried;
        logic [3:0] want_pid;
        rem = int'(num); off = 0; tog = 1;
        do begin
            n = (rem > MAXPKT) ? MAXPKT : rem;
            exp_pid.push_back(tog); exp_len.push_back(n); exp_off.push_back(off);
            rem -= n; off += n; tog ^= 1;
        end while (rem > 0);
        if (ZLP_EN && num != 0 && (int'(num) % MAXPKT) == 0) begin
            exp_pid.push_back(tog); exp_len.push_back(0); exp_off.push_back(off);
        end

        romaddr = addr; romnum = num; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        checks++;
        if (flush_tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load: flush_tx=%b busy=%b want 1 1", flush_tx, busy);
        end

        if (stall_at > 0) begin
            repeat (stall_at) tick();
            full_tx = 1'b1;
            for (int c = 0; c < 5; c++) begin
                in_token = (c == 2);
                #1;
                checks++;
                if (push_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_push: push_tx=%b want 0 while full", push_tx);
                end
                tick();
                in_token = 1'b0;
                if (c == 2) begin
                    checks++;
                    if (nak !== 1'b1 || tx_go !== 1'b0) begin
                        errors++;
                        $display("FAIL fill_nak: nak=%b tx_go=%b want 1 0", nak, tx_go);
                    end
                end
            end
            full_tx = 1'b0;
        end

        for (int p = 0; p < exp_pid.size(); p++) begin
            pkt_done = 1'b0; retried = 1'b0; tries = 0;
            want_pid = exp_pid[p] ? PID_DATA1 : PID_DATA0;
            while (!pkt_done) begin
                in_token = 1'b1;
                tick();
                in_token = 1'b0;
                tries++;
                if (tx_go === 1'b1) begin
                    checks++;
                    if (tx_pid !== want_pid) begin
                        errors++;
                        $display("FAIL pid pkt%0d: got %b want %b", p, tx_pid, want_pid);
                    end
                    checks++;
                    if (int'(tx_len) != exp_len[p]) begin
                        errors++;
                        $display("FAIL len pkt%0d: got %0d want %0d", p, tx_len, exp_len[p]);
                    end
                    checks++;
                    bad_idx = -1;
                    if (fifo.size() != exp_len[p]) bad_idx = 999;
                    else for (int i = 0; i < exp_len[p]; i++)
                        if (bad_idx < 0 &&
                            fifo[i] !== rom[(int'(addr) + exp_off[p] + i) & 511]) bad_idx = i;
                    if (bad_idx >= 0) begin
                        errors++;
                        $display("FAIL data pkt%0d: fifo bytes=%0d first bad=%0d want %0d bytes from rom[%0d]",
                                 p, fifo.size(), bad_idx, exp_len[p], (int'(addr) + exp_off[p]) & 511);
                    end
                    fifo.delete();
                    if (p == to_pkt && !retried) begin
                        retried = 1'b1;
                        ack_timeout = 1'b1;
                        tick();
                        ack_timeout = 1'b0;
                        checks++;
                        if (flush_tx !== 1'b1 || busy !== 1'b1) begin
                            errors++;
                            $display("FAIL timeout_flush: flush_tx=%b busy=%b want 1 1", flush_tx, busy);
                        end
                    end else if (p == lost_pkt && !retried) begin
                        retried = 1'b1;
                        tick();
                        in_token = 1'b1;
                        tick();
                        in_token = 1'b0;
                        checks++;
                        if (nak !== 1'b1 || tx_go !== 1'b0 || flush_tx !== 1'b1) begin
                            errors++;
                            $display("FAIL retry_in: nak=%b tx_go=%b flush_tx=%b want 1 0 1",
                                     nak, tx_go, flush_tx);
                        end
                    end else begin
                        ack_rcvd = 1'b1;
                        tick();
                        ack_rcvd = 1'b0;
                        pkt_done = 1'b1;
                    end
                end else if (nak === 1'b1) begin
                    repeat (6) tick();
                end else begin
                    errors++; checks++;
                    $display("FAIL in_response pkt%0d: tx_go=%b nak=%b want one of them", p, tx_go, nak);
                    return;
                end
                if (!pkt_done && tries > 200) begin
                    errors++; checks++;
                    $display("FAIL packet_wait pkt%0d: no tx_go after %0d INs", p, tries);
                    return;
                end
            end
        end

        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: busy=%b want 0", busy);
        end
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1 || tx_go !== 1'b0) begin
            errors++;
            $display("FAIL done_nak: nak=%b tx_go=%b want 1 0", nak, tx_go);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rom_addr, push_tx, datai_tx, flush_tx, tx_go, tx_pid, tx_len, nak, busy} !== '0) begin
            errors++;
            $display("FAIL reset: outputs=%h want 0",
                     {rom_addr, push_tx, datai_tx, flush_tx, tx_go, tx_pid, tx_len, nak, busy});
        end
        rst = 1'b0;
        tick();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1 || tx_go !== 1'b0) begin
            errors++;
            $display("FAIL idle_nak: nak=%b tx_go=%b want 1 0", nak, tx_go);
        end
    endtask

    task automatic test_single_packet();  run_transfer(9'd0,   8'd18,  -1, -1, 0); endtask
    task automatic test_two_packets();    run_transfer(9'd232, 8'd109, -1, -1, 0); endtask
    task automatic test_status_zlp();     run_transfer(9'd77,  8'd0,   -1, -1, 0); endtask
    task automatic test_timeout();        run_transfer(9'd40,  8'd59,   0, -1, 0); endtask
    task automatic test_lost_ack();       run_transfer(9'd490, 8'd70,  -1,  1, 0); endtask
    task automatic test_exact_multiple(); run_transfer(9'd300, 8'd128, -1, -1, 0); endtask

    task automatic test_stall();
        push_while_full = 0;
        run_transfer(9'd16, 8'd40, -1, -1, 9);
        checks++;
        if (push_while_full != 0) begin
            errors++;
            $display("FAIL push_full: pushes while full=%0d want 0", push_while_full);
        end
    endtask

    task automatic test_restart();
        romaddr = 9'd200; romnum = 8'd100; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        repeat (15) tick();
        run_transfer(9'd450, 8'd90, -1, -1, 0);
    endtask

    task automatic test_abort();
        int tries;
        romaddr = 9'd100; romnum = 8'd128; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        tries = 0;
        do begin
            repeat (6) tick();
            in_token = 1'b1;
            tick();
            in_token = 1'b0;
            tries++;
        end while (tx_go !== 1'b1 && tries < 100);
        ack_rcvd = 1'b1;
        tick();
        ack_rcvd = 1'b0;
        repeat (20) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: busy=%b want 1", busy);
        end
        setupdataactive = 1'b1;
        req_load = 1'b1;
        tick();
        req_load = 1'b0;
        checks++;
        if (flush_tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: flush_tx=%b busy=%b want 1 0", flush_tx, busy);
        end
        tick();
        checks++;
        if (flush_tx !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: flush_tx=%b busy=%b want 0 0", flush_tx, busy);
        end
        setupdataactive = 1'b0;
        tick();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1 || tx_go !== 1'b0) begin
            errors++;
            $display("FAIL abort_nak: nak=%b tx_go=%b want 1 0", nak, tx_go);
        end
        run_transfer(9'd5, 8'd18, -1, -1, 0);
    endtask

    task automatic test_random();
        logic [ROM_AW-1:0] a;
        logic [7:0] n;
        int to_p, lost_p;
        for (int k = 0; k < 6; k++) begin
            a      = ROM_AW'($urandom_range(0, 511));
            n      = 8'($urandom_range(0, 255));
            to_p   = int'($urandom_range(0, 4)) - 1;
            lost_p = int'($urandom_range(0, 4)) - 1;
            run_transfer(a, n, to_p, lost_p, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
        test_reset();
        test_single_packet();
        test_two_packets();
        test_status_zlp();
        test_timeout();
        test_lost_ack();
        test_stall();
        test_exact_multiple();
        test_restart();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_ep0_in_tx.md
Name: usb_ep0_in_tx

Overview:
EP0 IN-direction data responder; the transmit counterpart of the setup/standard-request decoder. Takes the descriptor window (ROM base address, byte count) produced after a SETUP is decoded, reads the descriptor ROM and splits the data into MAXPKT-sized DATAx packets. It pre-fills the ULPI TX FIFO, answers IN tokens with the correct PID and length, and tracks ACK/timeout for retransmission and data toggling. Also issues the zero-length DATA1 status packet for no-data control requests (e.g. SET_ADDRESS).

Parameters:
MAXPKT, 64, EP0 max packet size in bytes (8/16/32/64).
ROM_AW, 9, descriptor ROM address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_load  in  1  1-cycle pulse: decoder finished, window valid
romaddr  in  ROM_AW  descriptor start address, sampled on req_load
romnum  in  8  descriptor byte count, sampled on req_load; 0 = status ZLP only
setupdataactive  in  1  new SETUP in progress; aborts current transfer
rom_addr  out  ROM_AW  descriptor ROM read address
rom_data  in  8  ROM read data, valid 1 cycle after rom_addr
push_tx  out  1  TX FIFO write strobe
datai_tx  out  8  TX FIFO write data
full_tx  in  1  TX FIFO full
flush_tx  out  1  1-cycle pulse: discard TX FIFO contents
in_token  in  1  1-cycle pulse: IN token to this device, EP0
ack_rcvd  in  1  1-cycle pulse: host ACK for last DATA packet
ack_timeout  in  1  1-cycle pulse: no handshake within turnaround window
tx_go  out  1  1-cycle pulse: start sending packet
tx_pid  out  4  DATA0=4'b0011, DATA1=4'b1011
tx_len  out  7  bytes in packet (0..MAXPKT)
nak  out  1  1-cycle pulse: answer current IN with NAK
busy  out  1  transfer in progress (not IDLE/DONE)

Behaviour:
- Reset: all outputs 0; state IDLE; toggle=1; offset=0; remaining=0.
- Internal: base (ROM_AW), remaining (8b), offset (8b), pkt_len = min(remaining, MAXPKT), toggle, zlp_pending.
- IDLE: in_token -> nak. req_load -> latch base/remaining=romnum, offset=0, toggle=1 (first data stage packet is DATA1), flush_tx pulse, zlp_pending (see Optional Feature) -> FILL_ADDR.
- FILL_ADDR: drive rom_addr = base+offset+cnt (ROM_AW modulo, wraps) -> FILL_PUSH next cycle. If pkt_len==0, skip straight to WAIT_IN.
- FILL_PUSH: datai_tx=rom_data; assert push_tx only when !full_tx; hold (rom_addr held, data stable) while full. On push cnt++; cnt==pkt_len -> WAIT_IN, else FILL_ADDR. Throughput 1 byte / 2 cycles.
- in_token while FILL_* -> nak; filling continues.
- WAIT_IN: in_token -> tx_go pulse with tx_pid from toggle, tx_len=pkt_len (held stable until next tx_go) -> WAIT_HS.
- WAIT_HS: ack_rcvd -> offset+=pkt_len, remaining-=pkt_len, toggle flips, cnt=0. Then: remaining>0 -> FILL_ADDR; remaining==0 and zlp_pending -> clear zlp_pending, WAIT_IN with pkt_len 0; else DONE. Zero-length status packet (romnum=0) ACKed -> DONE.
- WAIT_HS: ack_timeout -> flush_tx, cnt=0, same offset/toggle -> FILL_ADDR (retransmit identical packet). in_token in WAIT_HS (host retry, ACK lost) treated as timeout then nak.
- ack_rcvd/ack_timeout outside WAIT_HS ignored.
- DONE: in_token -> nak; req_load -> as in IDLE.
- setupdataactive high in any state: highest priority; -> IDLE, flush_tx pulse (once, on entry), toggle=1, remaining=0. Overrides simultaneous req_load/in_token/ack.
- req_load simultaneous with setupdataactive ignored; req_load in any busy state restarts transfer (flush_tx, re-latch).
- busy=1 in FILL_*, WAIT_IN, WAIT_HS.

Optional Feature:
USB_EP0_TX_ZLP_EN: defined -> on req_load, zlp_pending=1 when romnum!=0 and romnum%MAXPKT==0; after last full packet ACKed, one extra ZLP with next toggle is sent before DONE. Undefined -> zlp_pending always 0; transfer ends after last data packet.

Test Plan:
- romnum=18, romaddr=0, MAXPKT=64 -> one packet, DATA1, tx_len=18, 18 pushes of ROM[0..17]; ACK -> DONE; next IN -> nak.
- romnum=109, romaddr=232 -> packets DATA1 len 64 (ROM 232..295), then DATA0 len 45 (ROM 296..340); DONE.
- romnum=0 after SET_ADDRESS -> no pushes, IN -> tx_go DATA1 tx_len=0; ACK -> DONE.
- romnum=59, ack_timeout after first tx_go -> flush_tx, refill same 59 bytes, next IN -> DATA1 again; ACK -> DONE.
- full_tx held high 5 cycles mid-fill -> push_tx 0 during stall, no byte lost/duplicated; IN during fill -> nak.
- romnum=128, MAXPKT=64: with USB_EP0_TX_ZLP_EN -> DATA1/64, DATA0/64, DATA1/0; without -> two packets then DONE. setupdataactive mid-second packet -> flush_tx, IDLE, busy=0.
